// File: rtl/core_status_pkg.sv
// Shared types and constants for the 2A03 processor status block:
// flag instruction encoding, P bit positions and the reset image.
package core_status_pkg;

   typedef enum logic [2:0] {
      FLAG_NONE = 3'd0,
      FLAG_CLC  = 3'd1,
      FLAG_SEC  = 3'd2,
      FLAG_CLI  = 3'd3,
      FLAG_SEI  = 3'd4,
      FLAG_CLV  = 3'd5,
      FLAG_CLD  = 3'd6,
      FLAG_SED  = 3'd7
   } flag_op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } req_state_t;

   localparam int P_C = 0;
   localparam int P_Z = 1;
   localparam int P_I = 2;
   localparam int P_D = 3;
   localparam int P_B = 4;
   localparam int P_U = 5;
   localparam int P_V = 6;
   localparam int P_N = 7;

   localparam logic [7:0] P_RESET_VAL = 8'h24;

endpackage

// File: rtl/core_status_if.sv
// Bus between the sequencer/ALU (master) and the status block (slave).
interface core_status_if;
   import core_status_pkg::*;

   logic     I_ready;
   logic     I_alu_we;
   logic     I_alu_carry;
   logic     I_alu_zero;
   logic     I_alu_overflow;
   logic     I_alu_sign;
   flag_op_t I_flag_op;
   logic     I_plp;
   logic [7:0] I_data;
   logic     I_push_brk;
   logic     I_nmi_n;
   logic     I_irq_n;
   logic     I_poll;
   logic     I_int_ack;

   logic     O_carry;
   logic     O_zero;
   logic     O_overflow;
   logic     O_sign;
   logic     O_decimal;
   logic     O_irq_disable;
   logic [7:0] O_p_push;
   logic     O_int_take;
   logic     O_int_nmi;

   modport master (
      output I_ready, I_alu_we, I_alu_carry, I_alu_zero, I_alu_overflow,
             I_alu_sign, I_flag_op, I_plp, I_data, I_push_brk, I_nmi_n,
             I_irq_n, I_poll, I_int_ack,
      input  O_carry, O_zero, O_overflow, O_sign, O_decimal, O_irq_disable,
             O_p_push, O_int_take, O_int_nmi
   );

   modport slave (
      input  I_ready, I_alu_we, I_alu_carry, I_alu_zero, I_alu_overflow,
             I_alu_sign, I_flag_op, I_plp, I_data, I_push_brk, I_nmi_n,
             I_irq_n, I_poll, I_int_ack,
      output O_carry, O_zero, O_overflow, O_sign, O_decimal, O_irq_disable,
             O_p_push, O_int_take, O_int_nmi
   );

endinterface

// File: rtl/core_nmi_edge.sv
// NMI falling-edge detector with a sticky pending flag. Runs every clock,
// independent of RDY, so an edge during a stall is never lost.
module core_nmi_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic nmi_n,
   input  logic clear,
   output logic pending
);

   logic prev_q, prev_d;
   logic pending_q, pending_d;
   logic fall;

   always_comb begin
      prev_d    = nmi_n;
      fall      = prev_q & ~nmi_n;
      pending_d = pending_q;
      // A fresh edge in the same cycle as the clear must survive.
      if (fall) begin
         pending_d = 1'b1;
      end else if (clear) begin
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q    <= 1'b1;
         pending_q <= 1'b0;
      end else begin
         prev_q    <= prev_d;
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;

endmodule

// File: rtl/core_status.sv
// 2A03 processor status register (NV-BDIZC) plus interrupt sampling:
// NMI edge / IRQ level detection and a registered request to the sequencer.
module core_status
   import core_status_pkg::*;
#(
   parameter logic [7:0] P_RESET = P_RESET_VAL
) (
   input  logic         I_clock,
   input  logic         I_reset_n,
   core_status_if.slave bus
);

   logic c_q, c_d;
   logic z_q, z_d;
   logic i_q, i_d;
   logic d_q, d_d;
   logic v_q, v_d;
   logic n_q, n_d;
   logic i_prev_q, i_prev_d;

   req_state_t state_q, state_d;
   logic       int_nmi_q, int_nmi_d;

   logic nmi_pending;
   logic nmi_clear;
   logic int_want;

   // Flag register: ack > PLP > ALU capture, flag op overriding its own bit only.
   always_comb begin
      c_d      = c_q;
      z_d      = z_q;
      i_d      = i_q;
      d_d      = d_q;
      v_d      = v_q;
      n_d      = n_q;
      i_prev_d = i_prev_q;
      if (bus.I_ready) begin
         i_prev_d = i_q;
         if (bus.I_plp) begin
            c_d = bus.I_data[P_C];
            z_d = bus.I_data[P_Z];
            i_d = bus.I_data[P_I];
            d_d = bus.I_data[P_D];
            v_d = bus.I_data[P_V];
            n_d = bus.I_data[P_N];
         end else begin
            if (bus.I_alu_we) begin
               c_d = bus.I_alu_carry;
               z_d = bus.I_alu_zero;
               v_d = bus.I_alu_overflow;
               n_d = bus.I_alu_sign;
            end
            case (bus.I_flag_op)
               FLAG_CLC: c_d = 1'b0;
               FLAG_SEC: c_d = 1'b1;
               FLAG_CLI: i_d = 1'b0;
               FLAG_SEI: i_d = 1'b1;
               FLAG_CLV: v_d = 1'b0;
               FLAG_CLD: d_d = 1'b0;
               FLAG_SED: d_d = 1'b1;
               default:  ;
            endcase
         end
         if (bus.I_int_ack) begin
            i_d = 1'b1;
         end
      end
   end

   always_ff @(posedge I_clock or negedge I_reset_n) begin
      if (!I_reset_n) begin
         c_q      <= P_RESET[P_C];
         z_q      <= P_RESET[P_Z];
         i_q      <= P_RESET[P_I];
         d_q      <= P_RESET[P_D];
         v_q      <= P_RESET[P_V];
         n_q      <= P_RESET[P_N];
         i_prev_q <= 1'b1;
      end else begin
         c_q      <= c_d;
         z_q      <= z_d;
         i_q      <= i_d;
         d_q      <= d_d;
         v_q      <= v_d;
         n_q      <= n_d;
         i_prev_q <= i_prev_d;
      end
   end

   core_nmi_edge u_nmi_edge (
      .clk     (I_clock),
      .rst_n   (I_reset_n),
      .nmi_n   (bus.I_nmi_n),
      .clear   (nmi_clear),
      .pending (nmi_pending)
   );

   // IRQ eligibility looks at the delayed I so CLI/SEI/PLP act one instruction late.
   assign int_want  = nmi_pending | (~bus.I_irq_n & ~i_prev_q);
   assign nmi_clear = bus.I_ready & bus.I_int_ack & (state_q == ST_REQ) & int_nmi_q;

   always_comb begin
      state_d   = state_q;
      int_nmi_d = int_nmi_q;
      if (bus.I_ready) begin
         case (state_q)
            ST_IDLE: begin
               if (bus.I_poll && int_want) begin
                  state_d   = ST_REQ;
                  int_nmi_d = nmi_pending;
               end
            end
            ST_REQ: begin
               if (bus.I_int_ack) begin
                  state_d   = ST_IDLE;
                  int_nmi_d = 1'b0;
               end else if (nmi_pending) begin
                  int_nmi_d = 1'b1;
               end
            end
            default: begin
               state_d   = ST_IDLE;
               int_nmi_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge I_clock or negedge I_reset_n) begin
      if (!I_reset_n) begin
         state_q   <= ST_IDLE;
         int_nmi_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         int_nmi_q <= int_nmi_d;
      end
   end

   assign bus.O_carry       = c_q;
   assign bus.O_zero        = z_q;
   assign bus.O_overflow    = v_q;
   assign bus.O_sign        = n_q;
   assign bus.O_decimal     = d_q;
   assign bus.O_irq_disable = i_q;
   assign bus.O_p_push      = {n_q, v_q, 1'b1, bus.I_push_brk, d_q, i_q, z_q, c_q};
   assign bus.O_int_take    = (state_q == ST_REQ);
   assign bus.O_int_nmi     = int_nmi_q;

endmodule

// File: doc/core_status.md
Name: core_status

Overview:
Processor status (P) register and interrupt-sampling block for the 2A03 core. It stores the NV-BDIZC flags, feeds C/Z/V/N back to the ALU, and captures the ALU's flag outputs after the ALU has already applied its P-mask. It also executes flag instructions, PLP and the push image for PHP/BRK/IRQ/NMI. It detects NMI edges and IRQ levels and raises a registered interrupt request to the sequencer.

Parameters:
P_RESET, 8'h24, P image after reset: I=1, bit5=1, all other flags 0.

Ports:
I_clock  in  1  core clock, rising edge
I_reset_n  in  1  asynchronous active-low reset
I_ready  in  1  cycle enable (RDY); when low, all flag and request state holds
I_alu_we  in  1  capture ALU flags this cycle
I_alu_carry / I_alu_zero / I_alu_overflow / I_alu_sign  in  1 each  ALU flag outputs
I_flag_op  in  3  flag_op_type: none, clc, sec, cli, sei, clv, cld, sed
I_plp  in  1  load P from I_data
I_data  in  8  pulled P byte
I_push_brk  in  1  B value for O_p_push (1 for PHP/BRK, 0 for IRQ/NMI)
I_nmi_n  in  1  NMI line, active low, pre-synchronised
I_irq_n  in  1  IRQ line, active low, pre-synchronised
I_poll  in  1  sequencer's interrupt poll point (last cycle of an instruction)
I_int_ack  in  1  sequencer has entered the interrupt sequence
O_carry / O_zero / O_overflow / O_sign  out  1 each  stored flags to ALU
O_decimal  out  1  D flag (stored only; the 2A03 has no BCD)
O_irq_disable  out  1  I flag
O_p_push  out  8  {N,V,1,I_push_brk,D,I,Z,C}, combinational
O_int_take  out  1  registered interrupt request
O_int_nmi  out  1  request is NMI (1) or IRQ (0)

Behaviour:
- Reset (asynchronous, while I_reset_n=0):
  - Flags = P_RESET.
  - nmi_pending=0, nmi_prev=1, i_prev=1.
  - O_int_take=0, O_int_nmi=0.
- NMI edge detector runs every clock regardless of I_ready:
  - nmi_prev <= I_nmi_n.
  - A falling edge (nmi_prev=1, I_nmi_n=0) sets nmi_pending.
  - A held-low line gives exactly one pending NMI.
- All remaining updates happen only on clock edges with I_ready=1.
- Flag update precedence, highest first:
  1. I_int_ack forces I=1.
  2. I_plp loads C,Z,I,D,V,N from I_data bits 0,1,2,3,6,7. Bits 4 and 5 are ignored.
  3. I_alu_we loads C,Z,V,N from the ALU.
  4. I_flag_op: if it is asserted together with I_alu_we, it overrides only its own bit.
- Bit 5 always reads 1. There is no stored B bit.
- I-flag latency:
  - i_prev <= O_irq_disable on every ready cycle.
  - IRQ eligibility uses i_prev, so CLI/SEI/PLP affect polling one ready cycle late. This delays the effect by one instruction, matching 6502 behaviour.
- Request FSM, IDLE and REQ:
  - IDLE -> REQ at a ready cycle with I_poll=1 when nmi_pending=1 or (I_irq_n=0 and i_prev=0).
  - On that transition, O_int_take <= 1 and O_int_nmi <= nmi_pending.
  - In REQ, any nmi_pending forces O_int_nmi <= 1 (NMI hijack of an IRQ/BRK entry).
  - In REQ, deassertion of I_irq_n does not cancel the request.
  - REQ -> IDLE on I_int_ack with I_ready=1: O_int_take <= 0, O_int_nmi <= 0.
  - If O_int_nmi=1 at the ack, nmi_pending is cleared. A new falling edge in the same cycle wins, and pending stays 1.
  - I_int_ack in IDLE sets I=1 only; there is no FSM change (BRK path).
  - I_poll in REQ is ignored.
- Reset asserted mid-request clears the request immediately; no partial state remains.
- Outputs O_carry..O_irq_disable are direct register outputs with zero added latency.

Decomposition:
- Shared include core_status.svi:
  - flag_op_type enum.
  - P bit-index constants (P_C=0, P_Z=1, P_I=2, P_D=3, P_B=4, P_U=5, P_V=6, P_N=7).
  - P_RESET value.
- One sub-module, core_nmi_edge: edge detector plus pending flag, with clear input and pending output.

Test Plan:
- Reset -> O_p_push with I_push_brk=1 equals 8'h34; O_int_take=0.
- I_ready=0 with I_alu_we=1 and ALU flags 4'b1111 -> flags unchanged. Raise I_ready -> C=Z=V=N=1.
- I_plp with I_data=8'hFF, then push with I_push_brk=0 -> O_p_push=8'hEF.
- I=1 and I_irq_n=0, then CLI followed by a poll in the very next ready cycle -> no take. The following poll -> O_int_take=1, O_int_nmi=0.
- I_nmi_n driven low and held for 20 cycles; poll, ack, poll again -> exactly one NMI request; the second poll gives no take.
- IRQ request pending in REQ, NMI falling edge before ack -> O_int_nmi rises to 1. Ack clears nmi_pending, I=1, O_int_take=0.
